// File: rtl/button_event_arbiter.sv
// Debounces NUM_BTN synchronized button levels and turns each debounced press into one event.
// Pending events are shared round-robin onto a single valid/ready event channel.
module button_event_arbiter #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter int unsigned ID_W            = 2
) (
    input  logic               button_clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [NUM_BTN-1:0] pending,
    output logic [NUM_BTN-1:0] overrun,
    input  logic               overrun_clr
);

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] stable_q, stable_d;
    logic [NUM_BTN-1:0] stable_prev_q;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] overrun_q, overrun_d;
    logic [ID_W-1:0]    evt_id_q, evt_id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;

    logic               handshake;
    logic               found;
    int unsigned        cand;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] deliver;

    // Debounce: counter only advances while the sample differs from the debounced level.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (btn_level[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = btn_level[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press     = stable_q & ~stable_prev_q;
    assign handshake = (state_q == S_OFFER) && evt_ready;
    assign deliver   = handshake ? (NUM_BTN'(1) << evt_id_q) : '0;

    // A press landing on the delivery edge of the same button re-arms it instead of overrunning.
    always_comb begin
        pending_d = press | (pending_q & ~deliver);
        overrun_d = (press & pending_q & ~deliver) | (overrun_clr ? '0 : overrun_q);
    end

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        found        = 1'b0;
        cand         = 0;
        case (state_q)
            S_IDLE: begin
                for (int unsigned j = 1; j <= NUM_BTN; j++) begin
                    cand = (int'(last_grant_q) + j) % NUM_BTN;
                    if (!found && pending_q[cand[ID_W-1:0]]) begin
                        found    = 1'b1;
                        evt_id_d = cand[ID_W-1:0];
                    end
                end
                if (found) begin
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (evt_ready) begin
                    last_grant_d = evt_id_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge button_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q      <= '0;
            stable_prev_q <= '0;
            pending_q     <= '0;
            overrun_q     <= '0;
            evt_id_q      <= '0;
            last_grant_q  <= ID_W'(NUM_BTN - 1);
            state_q       <= S_IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            evt_id_q      <= evt_id_d;
            last_grant_q  <= last_grant_d;
            state_q       <= state_d;
        end
    end

    assign evt_valid = (state_q == S_OFFER);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: debounce timing, round-robin order, hold, overrun, reset.
// Expected event ids are queued when presses are driven and checked on each handshake.
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_level = '0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready = 1'b0;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       overrun_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int exp_id;

    button_event_arbiter #(
        .NUM_BTN(4),
        .DEBOUNCE_CYCLES(16),
        .CNT_W(5),
        .ID_W(2)
    ) dut (
        .button_clk (clk),
        .reset      (reset),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .pending    (pending),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Handshake completes on the next rising edge; compare against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL sb_unexpected: observed id %0d, required no event", evt_id);
            end else begin
                exp_id = exp_q.pop_front();
                assert (32'(evt_id) === exp_id) else begin
                    fails++;
                    $error("FAIL sb_id: observed %0d required %0d", evt_id, exp_id);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Debounce latency on button 0
        btn_level = 4'b0001;
        exp_q.push_back(0);
        tick(16);
        chk("t1_pend_c16", 32'(pending), 32'd0);
        tick(1);
        chk("t1_pend_c17", 32'(pending), 32'h1);
        chk("t1_valid_c17", 32'(evt_valid), 32'd0);
        tick(1);
        chk("t1_valid_c18", 32'(evt_valid), 32'd1);
        chk("t1_id_c18", 32'(evt_id), 32'd0);
        evt_ready = 1'b1;
        tick(1);
        chk("t1_valid_after_hs", 32'(evt_valid), 32'd0);
        chk("t1_pend_after_hs", 32'(pending), 32'd0);
        btn_level = 4'b0000;
        tick(20);
        chk("t1_release_no_evt", 32'(pending), 32'd0);

        // Glitch of 15 samples is filtered
        btn_level = 4'b0100;
        tick(15);
        btn_level = 4'b0000;
        tick(20);
        chk("t2_pending", 32'(pending), 32'd0);
        chk("t2_valid", 32'(evt_valid), 32'd0);

        // Round-robin order from reset
        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_q.delete();
        btn_level = 4'b1011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick(17);
        chk("t3_pending", 32'(pending), 32'hB);
        tick(1);
        chk("t3_id0", 32'(evt_id), 32'd0);
        tick(1);
        chk("t3_gap", 32'(evt_valid), 32'd0);
        tick(1);
        chk("t3_id1", 32'(evt_id), 32'd1);
        tick(2);
        chk("t3_id3", 32'(evt_id), 32'd3);
        chk("t3_valid3", 32'(evt_valid), 32'd1);
        tick(1);
        chk("t3_drained", 32'(pending), 32'd0);
        btn_level = 4'b0000;
        tick(20);
        btn_level = 4'b0001;
        exp_q.push_back(0);
        tick(18);
        chk("t3_wrap_id0", 32'(evt_id), 32'd0);
        chk("t3_wrap_valid", 32'(evt_valid), 32'd1);
        tick(1);
        btn_level = 4'b0000;
        tick(20);

        // Offer held while consumer stalls
        evt_ready = 1'b0;
        btn_level = 4'b0010;
        exp_q.push_back(1);
        tick(18);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", 32'(evt_valid), 32'd1);
            chk("t4_hold_id", 32'(evt_id), 32'd1);
            tick(1);
        end
        evt_ready = 1'b1;
        tick(1);
        chk("t4_pend_cleared", 32'(pending), 32'd0);
        chk("t4_valid_low", 32'(evt_valid), 32'd0);
        btn_level = 4'b0000;
        tick(20);

        // Overrun set, clear, and press coinciding with delivery
        evt_ready = 1'b0;
        btn_level = 4'b1000;
        exp_q.push_back(3);
        tick(18);
        chk("t5_offer3", 32'(evt_id), 32'd3);
        btn_level = 4'b0000;
        tick(20);
        btn_level = 4'b1000;
        tick(16);
        chk("t5_no_ovr_yet", 32'(overrun), 32'd0);
        tick(1);
        chk("t5_overrun", 32'(overrun), 32'h8);
        chk("t5_pend3", 32'(pending), 32'h8);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("t5_ovr_clr", 32'(overrun), 32'd0);
        btn_level = 4'b0000;
        tick(20);
        btn_level = 4'b1000;
        exp_q.push_back(3);
        tick(16);
        evt_ready = 1'b1;
        tick(1);
        chk("t5_coinc_pend", 32'(pending), 32'h8);
        chk("t5_coinc_ovr", 32'(overrun), 32'd0);
        tick(1);
        chk("t5_reoffer", 32'(evt_valid), 32'd1);
        chk("t5_reoffer_id", 32'(evt_id), 32'd3);
        tick(1);
        chk("t5_drained", 32'(pending), 32'd0);
        btn_level = 4'b0000;
        tick(20);

        // Reset during an offer, then search restarts at index 0
        btn_level = 4'b0001;
        exp_q.push_back(0);
        tick(19);
        chk("t6_pre_pend", 32'(pending), 32'd0);
        btn_level = 4'b0000;
        tick(20);
        evt_ready = 1'b0;
        btn_level = 4'b0100;
        exp_q.push_back(2);
        tick(18);
        chk("t6_offer2", 32'(evt_id), 32'd2);
        btn_level = 4'b0000;
        tick(20);
        btn_level = 4'b0100;
        tick(17);
        chk("t6_ovr_before", 32'(overrun), 32'h4);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 32'd0);
        chk("t6_rst_pend", 32'(pending), 32'd0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        exp_q.delete();
        reset = 1'b0;
        btn_level = 4'b0101;
        evt_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(2);
        tick(18);
        chk("t6_first_id", 32'(evt_id), 32'd0);
        tick(2);
        chk("t6_second_id", 32'(evt_id), 32'd2);
        tick(2);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
